pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-width stage latches (e.g. MEM/WB) in the 5-stage MIPS pipeline.
- Registers one stage's control and data bundles behind a valid/ready handshake, with optional two-entry skid buffering.
- Supports synchronous flush, which kills control side effects, and an external stall.
- Keeps a saturating back-pressure counter for performance debug.
- Drop-in between any two pipeline stages.

Parameters:
- CTRL_W, 3, width of control bundle (write enables); zeroed on flush/bubble.
- DATA_W, 133, width of data bundle (aluout, readdata, hilo, writereg); never masked.
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single entry with combinational ready_o.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- stall  in  1  external hold; blocks acceptance and issue
- valid_i  in  1  upstream entry valid
- ready_o  out  1  stage can accept this cycle
- ctrl_i  in  CTRL_W  upstream control bundle
- data_i  in  DATA_W  upstream data bundle
- valid_o  out  1  downstream entry valid
- ready_i  in  1  downstream accepts
- ctrl_o  out  CTRL_W  control out; forced 0 when valid_o=0
- data_o  out  DATA_W  data out (head entry)
- occ_o  out  2  occupancy 0..2 (0..1 when SKID=0)
- cnt_clr  in  1  synchronous clear of stall counter
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and (ready_i=0 or stall=1)

Behaviour:
- Reset (reset=0, async): all valid bits 0, ctrl/data regs 0, stall_cnt_o 0, occ_o 0. With SKID=1, ready_o=0 while in reset and 1 from the first cycle after release.
- Handshakes:
  - Accept = valid_i & ready_o & ~stall & ~flush.
  - Issue = valid_o & ready_i & ~stall.
  - Latency valid_i→valid_o is exactly 1 cycle when the stage is empty.
- States (SKID=1): EMPTY(occ 0), ONE(occ 1, main reg valid), FULL(occ 2, main+skid valid). ready_o = (state != FULL), registered.
  - EMPTY: accept → ONE.
  - ONE: accept&~issue → FULL (new entry to skid reg); issue&~accept → EMPTY; accept&issue → ONE (main reloaded).
  - FULL: issue → ONE (skid moves to main, order preserved); no accept possible.
- SKID=0: single reg. ready_o = ~valid_o | (ready_i & ~stall), combinational. Simultaneous issue+accept reloads in the same cycle.
- Flush: highest priority after reset. Next cycle occ=0, all valid 0, stored ctrl regs 0; data regs keep their value. An upstream entry presented in the flush cycle is dropped.
- stall=1: no accept, no issue. State holds and registers hold. ctrl_o stays visible if valid.
- ctrl_o = valid_o ? head ctrl : 0, so a bubble never asserts a write enable.
- Ordering: strict FIFO; no entry is duplicated or lost except on flush.
- Stall counter:
  - Increments when valid_o & (~ready_i | stall); saturates at all-ones with no wrap.
  - cnt_clr sets it to 0 and wins over increment. Flush does not clear it.
- Reset mid-transfer: entries are discarded immediately; no partial output.

Decomposition:
- Shared package pipe_pkg: state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2), default widths for the MEM/WB bundle (CTRL_W_MW=3, DATA_W_MW=133).
- One natural sub-module: pipe_entry_reg. It is a single {valid, ctrl, data} register with async active-low reset, load enable and sync flush that clears valid+ctrl. It is instantiated twice (main, skid) when SKID=1, once when SKID=0.
- Counter stays inline.

Test Plan:
- Reset/pass-through: reset=0 for 2 cycles, then valid_i=1 with ctrl=3'b101, data=0xA5 held 1 cycle, ready_i=1 → next cycle valid_o=1, ctrl_o=3'b101, data_o=0xA5, occ_o=1; the cycle after, valid_o=0, ctrl_o=0.
- Skid fill/drain (SKID=1): ready_i=0, send D1=0x11 and D2=0x22 back-to-back.
  - Expect occ_o=2 and ready_o=0 with D3 held off; stall_cnt_o increments each blocked cycle.
  - Raise ready_i: outputs 0x11, 0x22, then D3 in order, no gaps once ready.
- Flush in FULL with valid_i=1 on the same cycle → next cycle occ_o=0, valid_o=0, ctrl_o=0; upstream entry not captured; stall_cnt_o unchanged.
- Stall: occ=1, stall=1 for 3 cycles with ready_i=1 and valid_i=1 → no issue, no accept; data_o stable; stall_cnt_o +3.
- Counter saturation/clear: CNT_W=4, hold back-pressure 20 cycles → stall_cnt_o=15. Then cnt_clr=1 together with back-pressure → 0.
- SKID=0 throughput: continuous valid_i and ready_i for 8 entries → 1 entry/cycle, ready_o=1 throughout. Drop ready_i mid-stream → ready_o falls combinationally in the same cycle; no entry lost.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and
// default bundle widths for the MEM/WB boundary.
package pipe_pkg;

    // Occupancy-coded states of the two-entry skid stage (value == occupancy).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // MEM/WB bundle widths: write enables / aluout, readdata, hilo, writereg.
    localparam int CTRL_W_MW = 3;
    localparam int DATA_W_MW = 133;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {valid, ctrl, data} holding register. Flush and bubble loads clear
// valid and ctrl; data is only overwritten by a real entry.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_MW,
    parameter int DATA_W = DATA_W_MW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry register: flush beats load, bubbles never carry a write enable.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_ctrl  <= i_valid ? i_ctrl : '0;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, optional two-entry skid
// buffer, synchronous flush, external stall and a saturating stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_MW,
    parameter int DATA_W = DATA_W_MW,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              w_accept;
    logic              w_issue;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_accept = valid_i & ready_o & ~stall & ~flush;
    assign w_issue  = w_main_valid & ready_i & ~stall;

    assign valid_o = w_main_valid;
    assign ctrl_o  = w_main_valid ? w_main_ctrl : '0;
    assign data_o  = w_main_data;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e       r_state;
            pipe_state_e       w_state_nxt;
            logic              r_ready;
            logic              w_main_load;
            logic              w_main_src_valid;
            logic [CTRL_W-1:0] w_main_src_ctrl;
            logic [DATA_W-1:0] w_main_src_data;
            logic              w_skid_load;
            logic              w_skid_src_valid;
            logic              w_skid_valid;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;

            // State register; ready is registered from the next state.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= ST_EMPTY;
                    r_ready <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_ready <= (w_state_nxt != ST_FULL);
                end
            end

            // Next state and entry-register load steering.
            always_comb begin
                // NOTE: every output gets a default first so no latch is inferred.
                w_state_nxt      = r_state;
                w_main_load      = 1'b0;
                w_main_src_valid = 1'b0;
                w_main_src_ctrl  = ctrl_i;
                w_main_src_data  = data_i;
                w_skid_load      = 1'b0;
                w_skid_src_valid = 1'b0;
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    unique case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                w_main_load      = 1'b1;
                                w_main_src_valid = 1'b1;
                                w_state_nxt      = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_issue) begin
                                w_main_load      = 1'b1;
                                w_main_src_valid = 1'b1;
                            end else if (w_accept) begin
                                w_skid_load      = 1'b1;
                                w_skid_src_valid = 1'b1;
                                w_state_nxt      = ST_FULL;
                            end else if (w_issue) begin
                                w_main_load = 1'b1;
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (w_issue) begin
                                w_main_load      = 1'b1;
                                w_main_src_valid = w_skid_valid;
                                w_main_src_ctrl  = w_skid_ctrl;
                                w_main_src_data  = w_skid_data;
                                w_skid_load      = 1'b1;
                                w_state_nxt      = ST_ONE;
                            end
                        end
                        default: w_state_nxt = ST_EMPTY;
                    endcase
                end
            end

            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk     (clk),
                .reset   (reset),
                .i_flush (flush),
                .i_load  (w_main_load),
                .i_valid (w_main_src_valid),
                .i_ctrl  (w_main_src_ctrl),
                .i_data  (w_main_src_data),
                .o_valid (w_main_valid),
                .o_ctrl  (w_main_ctrl),
                .o_data  (w_main_data)
            );

            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_flush (flush),
                .i_load  (w_skid_load),
                .i_valid (w_skid_src_valid),
                .i_ctrl  (ctrl_i),
                .i_data  (data_i),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );

            assign ready_o = r_ready;
            assign occ_o   = r_state;
        end else begin : g_noskid
            // Single entry: reload on accept, drain to a bubble on a lone issue.
            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk     (clk),
                .reset   (reset),
                .i_flush (flush),
                .i_load  (w_accept | w_issue),
                .i_valid (w_accept),
                .i_ctrl  (ctrl_i),
                .i_data  (data_i),
                .o_valid (w_main_valid),
                .o_ctrl  (w_main_ctrl),
                .o_data  (w_main_data)
            );

            assign ready_o = ~w_main_valid | (ready_i & ~stall);
            assign occ_o   = {1'b0, w_main_valid};
        end
    endgenerate

    // Saturating count of cycles a valid head is held back; clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && (!ready_i || stall) && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid instance (CNT_W=4) and a single-entry
// instance share one directed stimulus; queue models predict both every cycle.
module tb_pipe_stage_elastic;

    localparam int CW = 3;
    localparam int DW = 133;
    localparam int CNT1_MAX = 15;
    localparam int CNT0_MAX = 65535;

    logic          clk;
    logic          reset;
    logic          flush, stall, valid_i, ready_i, cnt_clr;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] data_i;

    logic          ready_o1, valid_o1, ready_o0, valid_o0;
    logic [CW-1:0] ctrl_o1, ctrl_o0;
    logic [DW-1:0] data_o1, data_o0;
    logic [1:0]    occ_o1, occ_o0;
    logic [3:0]    cnt_o1;
    logic [15:0]   cnt_o0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t m1_q[$];
    ent_t m0_q[$];
    int   m1_cnt = 0;
    int   m0_cnt = 0;
    bit   m1_live = 0;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .valid_i(valid_i), .ready_o(ready_o1), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_o1), .ready_i(ready_i), .ctrl_o(ctrl_o1), .data_o(data_o1),
        .occ_o(occ_o1), .cnt_clr(cnt_clr), .stall_cnt_o(cnt_o1)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .valid_i(valid_i), .ready_o(ready_o0), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_o0), .ready_i(ready_i), .ctrl_o(ctrl_o0), .data_o(data_o0),
        .occ_o(occ_o0), .cnt_clr(cnt_clr), .stall_cnt_o(cnt_o0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one edge: a bounded FIFO with the handshake rules applied.
    task automatic model_step();
        bit rdy1, rdy0, iss1, iss0, acc1, acc0;
        ent_t e;
        e.ctrl = ctrl_i;
        e.data = data_i;
        rdy1 = m1_live && (m1_q.size() < 2);
        rdy0 = (m0_q.size() == 0) || (ready_i && !stall);
        iss1 = (m1_q.size() > 0) && ready_i && !stall;
        iss0 = (m0_q.size() > 0) && ready_i && !stall;
        acc1 = valid_i && rdy1 && !stall && !flush;
        acc0 = valid_i && rdy0 && !stall && !flush;
        if (cnt_clr) m1_cnt = 0;
        else if (m1_q.size() > 0 && (!ready_i || stall) && m1_cnt < CNT1_MAX) m1_cnt++;
        if (cnt_clr) m0_cnt = 0;
        else if (m0_q.size() > 0 && (!ready_i || stall) && m0_cnt < CNT0_MAX) m0_cnt++;
        if (flush) begin
            m1_q.delete();
            m0_q.delete();
        end else begin
            if (iss1) void'(m1_q.pop_front());
            if (acc1) m1_q.push_back(e);
            if (iss0) void'(m0_q.pop_front());
            if (acc0) m0_q.push_back(e);
        end
        m1_live = 1;
    endtask

    task automatic compare_all();
        if (!reset) begin
            m1_q.delete();
            m0_q.delete();
            m1_cnt  = 0;
            m0_cnt  = 0;
            m1_live = 0;
            check("rst s1 valid_o", valid_o1, 0);
            check("rst s1 ready_o", ready_o1, 0);
            check("rst s1 ctrl_o", ctrl_o1, 0);
            check("rst s1 data_o", data_o1, 0);
            check("rst s1 occ_o", occ_o1, 0);
            check("rst s1 cnt", cnt_o1, 0);
            check("rst s0 valid_o", valid_o0, 0);
            check("rst s0 ctrl_o", ctrl_o0, 0);
            check("rst s0 data_o", data_o0, 0);
            check("rst s0 occ_o", occ_o0, 0);
            check("rst s0 cnt", cnt_o0, 0);
        end else begin
            check("s1 valid_o", valid_o1, m1_q.size() != 0);
            check("s1 ctrl_o", ctrl_o1, (m1_q.size() != 0) ? m1_q[0].ctrl : 3'd0);
            if (m1_q.size() != 0) check("s1 data_o", data_o1, m1_q[0].data);
            check("s1 occ_o", occ_o1, m1_q.size());
            check("s1 ready_o", ready_o1, m1_live && (m1_q.size() < 2));
            check("s1 cnt", cnt_o1, m1_cnt);
            check("s0 valid_o", valid_o0, m0_q.size() != 0);
            check("s0 ctrl_o", ctrl_o0, (m0_q.size() != 0) ? m0_q[0].ctrl : 3'd0);
            if (m0_q.size() != 0) check("s0 data_o", data_o0, m0_q[0].data);
            check("s0 occ_o", occ_o0, m0_q.size());
            check("s0 ready_o", ready_o0, (m0_q.size() == 0) || (ready_i && !stall));
            check("s0 cnt", cnt_o0, m0_cnt);
        end
    endtask

    bit run = 1;

    // Model advances on the active edge using the inputs held across it.
    initial forever begin
        @(posedge clk);
        if (reset) model_step();
    end

    // Single compare process, sampling mid-cycle after inputs settle.
    initial forever begin
        @(negedge clk);
        #2;
        if (run) compare_all();
    end

    // Drive one cycle of inputs at the falling edge; return after the compare.
    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic r, input logic stl, input logic fl, input logic clr);
        @(negedge clk);
        valid_i = v;
        ctrl_i  = c;
        data_i  = d;
        ready_i = r;
        stall   = stl;
        flush   = fl;
        cnt_clr = clr;
        #3;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, '0, '0, r, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; stall = 1'b0; valid_i = 1'b0;
        ready_i = 1'b1; cnt_clr = 1'b0; ctrl_i = '0; data_i = '0;

        // Reset and first-cycle ready.
        idle(1'b1);
        idle(1'b1);
        check("lit rst ready", ready_o1, 0);
        check("lit rst occ", occ_o1, 0);
        @(negedge clk);
        reset = 1'b1;
        #3;
        check("lit ready before first edge", ready_o1, 0);

        // Pass-through with one-cycle latency.
        drive(1'b1, 3'b101, 'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lit ready after release", ready_o1, 1);
        idle(1'b1);
        check("lit pass valid", valid_o1, 1);
        check("lit pass ctrl", ctrl_o1, 3'b101);
        check("lit pass data", data_o1, 'hA5);
        check("lit pass occ", occ_o1, 1);
        check("lit pass s0 data", data_o0, 'hA5);
        idle(1'b1);
        check("lit bubble valid", valid_o1, 0);
        check("lit bubble ctrl", ctrl_o1, 0);

        // Skid fill and in-order drain.
        drive(1'b1, 3'd1, 'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit fill occ1", occ_o1, 1);
        drive(1'b1, 3'd3, 'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit full occ", occ_o1, 2);
        check("lit full ready", ready_o1, 0);
        check("lit full cnt", cnt_o1, 1);
        drive(1'b1, 3'd3, 'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit blocked cnt", cnt_o1, 2);
        drive(1'b1, 3'd3, 'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lit drain d1", data_o1, 'h11);
        check("lit drain cnt", cnt_o1, 3);
        drive(1'b1, 3'd3, 'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lit drain d2", data_o1, 'h22);
        idle(1'b1);
        check("lit drain d3", data_o1, 'h33);
        check("lit drain d3 valid", valid_o1, 1);
        idle(1'b1);
        check("lit drained occ", occ_o1, 0);

        // Flush while full, with an upstream entry offered in the same cycle.
        drive(1'b1, 3'd7, 'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 'h66, 1'b1, 1'b0, 1'b1, 1'b0);
        check("lit pre-flush occ", occ_o1, 2);
        check("lit pre-flush cnt", cnt_o1, 4);
        idle(1'b1);
        check("lit flush occ", occ_o1, 0);
        check("lit flush valid", valid_o1, 0);
        check("lit flush ctrl", ctrl_o1, 0);
        check("lit flush cnt kept", cnt_o1, 4);
        check("lit flush ready", ready_o1, 1);

        // External stall for three cycles.
        drive(1'b1, 3'd1, 'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd2, 'h88, 1'b1, 1'b1, 1'b0, 1'b0);
            check("lit stall data", data_o1, 'h77);
        end
        idle(1'b1);
        check("lit stall cnt+3", cnt_o1, 7);
        check("lit stall occ", occ_o1, 1);
        check("lit stall ctrl", ctrl_o1, 1);
        idle(1'b1);
        check("lit stall released", valid_o1, 0);

        // Counter saturation and clear-over-increment.
        drive(1'b1, 3'd3, 'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lit cnt saturated", cnt_o1, 15);
        idle(1'b0);
        check("lit cnt cleared", cnt_o1, 0);
        idle(1'b1);
        check("lit cnt restart", cnt_o1, 1);
        idle(1'b1);

        // Back-to-back throughput, then a mid-stream ready drop.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, CW'(k), DW'(256 + k), 1'b1, 1'b0, 1'b0, 1'b0);
            check("lit tput s0 ready", ready_o0, 1);
            if (k > 0) check("lit tput s0 data", data_o0, 256 + k - 1);
        end
        drive(1'b1, 3'd4, 'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lit s0 ready comb fall", ready_o0, 0);
        check("lit s0 head", data_o0, 'h107);
        drive(1'b1, 3'd4, 'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lit s0 ready comb rise", ready_o0, 1);
        check("lit s1 full occ", occ_o1, 2);
        idle(1'b1);
        check("lit s0 tail", data_o0, 'h1FF);
        check("lit s1 tail", data_o1, 'h1FF);
        idle(1'b1);

        // Reset asserted mid-transfer discards entries at once.
        drive(1'b1, 3'd2, 'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("lit midrst valid", valid_o1, 0);
        check("lit midrst data", data_o1, 0);
        check("lit midrst s0 valid", valid_o0, 0);
        idle(1'b1);
        @(negedge clk);
        reset = 1'b1;
        #3;
        idle(1'b1);
        idle(1'b1);
        check("lit post-rst ready", ready_o1, 1);
        check("lit post-rst occ", occ_o1, 0);

        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
